// File: rtl/ldtu_ofifo_param.sv
// Output storage FIFO for Hamming-encoded LiTe-DTU words: level-based full/empty,
// registered head word, almost-full, flush, and overflow/underflow diagnostics.
module ldtu_ofifo_param #(
  parameter int unsigned NBITS_HAM  = 38,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AFULL_THR  = 12,
  parameter int unsigned OVF_BITS   = 8,
  parameter logic [NBITS_HAM-1:0] RESET_WORD = 38'h0040000000
) (
  input  logic                  CLK,
  input  logic                  rst_b,
  input  logic                  flush,
  input  logic                  start_write,
  input  logic [NBITS_HAM-1:0]  data_input,
  input  logic                  read_signal,
  output logic [NBITS_HAM-1:0]  data_output,
  output logic                  decode_signal,
  output logic                  empty_signal,
  output logic                  full_signal,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic [OVF_BITS-1:0]   ovf_count,
  output logic                  underflow,
  input  logic                  clr_diag,
  output logic                  SeuError
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_AFULL = (DEPTH_LOG2+1)'(AFULL_THR);
  localparam logic [OVF_BITS-1:0] OVF_MAX   = '1;

  logic [NBITS_HAM-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr_write, ptr_read;
  logic [DEPTH_LOG2:0]   lvl;
  logic rd_ok, wr_ok, ovf_ev, unf_ev;

  assign level        = lvl;
  assign empty_signal = (lvl == '0);
  assign full_signal  = (lvl == LVL_FULL);
  assign almost_full  = (lvl >= LVL_AFULL);
  assign SeuError     = 1'b0;

  // A read frees a slot in the same cycle, so a write into a full FIFO is legal alongside it.
  assign rd_ok  = read_signal & ~empty_signal;
  assign wr_ok  = start_write & (~full_signal | rd_ok);
  assign ovf_ev = start_write & full_signal & ~rd_ok;
  assign unf_ev = read_signal & empty_signal;

  always_ff @(posedge CLK) begin
    if (rst_b && !flush && wr_ok) mem[ptr_write] <= data_input;
  end

  always_ff @(posedge CLK) begin
    if (!rst_b || flush) begin
      ptr_write     <= '0;
      ptr_read      <= '0;
      lvl           <= '0;
      data_output   <= RESET_WORD;
      decode_signal <= 1'b0;
    end else begin
      if (wr_ok) ptr_write <= ptr_write + 1'b1;
      if (rd_ok) begin
        data_output <= mem[ptr_read];
        ptr_read    <= ptr_read + 1'b1;
      end
      decode_signal <= rd_ok;
      if (wr_ok && !rd_ok)      lvl <= lvl + 1'b1;
      else if (rd_ok && !wr_ok) lvl <= lvl - 1'b1;
    end
  end

  // Diagnostics survive flush; a same-cycle clear beats any new event.
  always_ff @(posedge CLK) begin
    if (!rst_b || clr_diag) begin
      ovf_count <= '0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (ovf_ev && ovf_count != OVF_MAX) ovf_count <= ovf_count + 1'b1;
      if (unf_ev) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ldtu_ofifo_param.sv
// Randomised scoreboard bench for ldtu_ofifo_param against a queue-based reference model.
module tb_ldtu_ofifo_param;
  localparam int NB = 38;
  localparam int DL2 = 4;
  localparam int DEPTH = 16;
  localparam int AFT = 12;
  localparam int OVB = 8;
  localparam logic [NB-1:0] RW = 38'h0040000000;

  logic CLK = 0;
  logic rst_b = 0, flush = 0, start_write = 0, read_signal = 0, clr_diag = 0;
  logic [NB-1:0] data_input = '0;
  logic [NB-1:0] data_output;
  logic decode_signal, empty_signal, full_signal, almost_full, underflow, SeuError;
  logic [DL2:0] level;
  logic [OVB-1:0] ovf_count;

  ldtu_ofifo_param #(.NBITS_HAM(NB), .DEPTH_LOG2(DL2), .AFULL_THR(AFT), .OVF_BITS(OVB),
                     .RESET_WORD(RW)) dut (
    .CLK(CLK), .rst_b(rst_b), .flush(flush), .start_write(start_write),
    .data_input(data_input), .read_signal(read_signal), .data_output(data_output),
    .decode_signal(decode_signal), .empty_signal(empty_signal), .full_signal(full_signal),
    .almost_full(almost_full), .level(level), .ovf_count(ovf_count), .underflow(underflow),
    .clr_diag(clr_diag), .SeuError(SeuError));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;
  logic [NB-1:0] mq[$];
  logic [NB-1:0] exp_q[$];
  int m_ovf = 0;
  bit m_unf = 0, m_dec = 0;
  logic [NB-1:0] m_out = RW;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every popped word must match the scoreboard head.
  always @(negedge CLK) begin
    if (decode_signal === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 64'(data_output), 64'hDEAD);
      else chk("pop_data", 64'(data_output), 64'(exp_q.pop_front()));
    end
  end

  // Model the upcoming edge from the specification's rules, apply inputs, then check state.
  task automatic step(input bit sw, input logic [NB-1:0] d, input bit rs,
                      input bit fl, input bit cd, input bit rb);
    bit rd, wr, full, oev, uev;
    rst_b = rb; flush = fl; clr_diag = cd;
    start_write = sw; data_input = d; read_signal = rs;
    if (!rb) begin
      mq.delete(); m_ovf = 0; m_unf = 0; m_out = RW; m_dec = 0;
    end else if (fl) begin
      mq.delete(); m_out = RW; m_dec = 0;
      if (cd) begin m_ovf = 0; m_unf = 0; end
    end else begin
      full = (mq.size() == DEPTH);
      rd = rs && mq.size() > 0;
      wr = sw && (!full || rd);
      oev = sw && full && !rd;
      uev = rs && mq.size() == 0;
      m_dec = rd;
      if (rd) begin m_out = mq.pop_front(); exp_q.push_back(m_out); end
      if (wr) mq.push_back(d);
      if (cd) begin m_ovf = 0; m_unf = 0; end
      else begin
        if (oev && m_ovf < 255) m_ovf++;
        if (uev) m_unf = 1;
      end
    end
    @(posedge CLK); #1;
    chk("level", 64'(level), 64'(mq.size()));
    chk("empty", 64'(empty_signal), 64'(mq.size() == 0));
    chk("full", 64'(full_signal), 64'(mq.size() == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(mq.size() >= AFT));
    chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_unf));
    chk("decode", 64'(decode_signal), 64'(m_dec));
    if (!m_dec) chk("data_hold", 64'(data_output), 64'(m_out));
  endtask

  task automatic wr(input logic [NB-1:0] d); step(1, d, 0, 0, 0, 1); endtask
  task automatic rd(); step(0, '0, 1, 0, 0, 1); endtask

  function automatic logic [NB-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NB-1:0];
  endfunction

  initial begin
    logic [NB-1:0] w;
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    chk("SeuError", 64'(SeuError), 64'd0);

    // 1: fill, overflow once, drain in order
    for (int i = 1; i <= 16; i++) wr(NB'(i));
    wr(38'h3FF);
    for (int i = 0; i < 16; i++) rd();

    // 2: simultaneous read/write while full across pointer wrap
    for (int i = 0; i < 16; i++) wr(rnd());
    for (int i = 0; i < 20; i++) step(1, rnd(), 1, 0, 0, 1);
    for (int i = 0; i < 16; i++) rd();

    // 3: read on empty with same-cycle write
    step(1, 38'hABC, 1, 0, 0, 1);
    rd();
    step(0, '0, 0, 0, 1, 1);

    // 4: flush with same-cycle write, then new word lands in slot 0
    for (int i = 0; i < 5; i++) wr(rnd());
    step(1, rnd(), 1, 1, 0, 1);
    w = rnd();
    wr(w);
    chk("slot0_after_flush", 64'(dut.mem[0]), 64'(w));
    rd();

    // 5: saturate overflow counter, clear wins over same-cycle overflow
    for (int i = 0; i < 16; i++) wr(rnd());
    for (int i = 0; i < 300; i++) wr(rnd());
    step(1, rnd(), 0, 0, 1, 1);
    step(0, '0, 0, 1, 0, 1);

    // 6: reset mid read burst
    for (int i = 0; i < 8; i++) wr(rnd());
    for (int i = 0; i < 3; i++) rd();
    step(0, '0, 1, 0, 0, 0);
    w = rnd();
    wr(w);
    chk("slot0_after_reset", 64'(dut.mem[0]), 64'(w));
    rd();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 55, rnd(), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) != 0);
    end
    step(0, '0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
